// File: rtl/lsu_pkg.sv
// lsu_pkg: size/error encodings, FSM states and byte-mask helper for the LSU
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FAULT    = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: request, response and physical-memory signals of the LSU
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_rd_en;
  logic [63:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        mem_we_en;
  logic [63:0] mem_we_addr;
  logic [63:0] mem_we_data;
  logic [7:0]  mem_we_mask;
  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
  );
  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
  );
endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: picks the low 2^size bytes of raw load data and sign/zero extends them
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [63:0] i_raw,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [63:0] o_data
);
  always_comb
    o_data = i_size == SZ_B ? {{56{i_signed & i_raw[7]}},  i_raw[7:0]}  :
             i_size == SZ_H ? {{48{i_signed & i_raw[15]}}, i_raw[15:0]} :
             i_size == SZ_W ? {{32{i_signed & i_raw[31]}}, i_raw[31:0]} : i_raw;
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: one-at-a-time load/store initiator with alignment/range checks
// and flop-driven, single-cycle memory enables
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter logic [63:0] PMEM_BASE = 64'h8000_0000,
  parameter logic [63:0] PMEM_SIZE = 64'h0800_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  lsu_mem_master_if.master io_bus
);
  state_t      r_state, w_next;
  logic        w_acc, w_mis, w_fault;
  logic [1:0]  w_err;
  logic [64:0] w_bytes;
  logic [7:0]  w_bmask;
  logic [63:0] w_dmask, w_ext;
  logic        r_write, r_signed, r_rd_en, r_we_en;
  logic [1:0]  r_size, r_err;
  logic [63:0] r_rdata, r_rd_addr, r_we_addr, r_we_data;
  logic [7:0]  r_we_mask;
  assign w_bytes = 65'd1 << io_bus.req_size;
  assign w_mis   = |(io_bus.req_addr & (w_bytes[63:0] - 64'd1));
  // 65-bit end address so a request near 2^64 cannot wrap into the window
  assign w_fault = io_bus.req_addr < PMEM_BASE ||
                   ({1'b0, io_bus.req_addr} + w_bytes) > ({1'b0, PMEM_BASE} + {1'b0, PMEM_SIZE});
  assign w_err   = w_mis ? ERR_MISALIGN : w_fault ? ERR_FAULT : ERR_OK;
  assign w_bmask = size_mask(io_bus.req_size);
  for (genvar b = 0; b < 8; b++) begin : g_dmask
    assign w_dmask[8*b +: 8] = {8{w_bmask[b]}};
  end
  lsu_load_ext u_ext (
    .i_raw    (io_bus.mem_rd_data),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );
  always_comb begin
    w_acc  = r_state == S_IDLE && io_bus.req_valid;
    w_next = r_state == S_IDLE   ? (io_bus.req_valid ? S_ACCESS : S_IDLE) :
             r_state == S_ACCESS ? S_RESP : (io_bus.resp_ready ? S_IDLE : S_RESP);
    io_bus.req_ready  = r_state == S_IDLE;
    io_bus.resp_valid = r_state == S_RESP;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_write   <= 1'b0;
      r_signed  <= 1'b0;
      r_size    <= SZ_B;
      r_err     <= ERR_OK;
      r_rdata   <= '0;
      r_rd_en   <= 1'b0;
      r_we_en   <= 1'b0;
      r_rd_addr <= '0;
      r_we_addr <= '0;
      r_we_data <= '0;
      r_we_mask <= '0;
    end else begin
      r_state <= w_next;
      r_rd_en <= w_acc && !io_bus.req_write && w_err == ERR_OK;
      r_we_en <= w_acc && io_bus.req_write && w_err == ERR_OK;
      if (w_acc) begin
        r_write   <= io_bus.req_write;
        r_signed  <= io_bus.req_signed;
        r_size    <= io_bus.req_size;
        r_err     <= w_err;
        r_rd_addr <= io_bus.req_addr;
        r_we_addr <= io_bus.req_addr;
        r_we_data <= io_bus.req_wdata & w_dmask;
        r_we_mask <= w_bmask;
      end
      if (r_state == S_ACCESS)
        r_rdata <= (!r_write && r_err == ERR_OK) ? w_ext : '0;
    end
  assign io_bus.resp_rdata  = r_rdata;
  assign io_bus.resp_err    = r_err;
  assign io_bus.mem_rd_en   = r_rd_en;
  assign io_bus.mem_rd_addr = r_rd_addr;
  assign io_bus.mem_we_en   = r_we_en;
  assign io_bus.mem_we_addr = r_we_addr;
  assign io_bus.mem_we_data = r_we_data;
  assign io_bus.mem_we_mask = r_we_mask;
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed and random load/store transactions against an arithmetic reference model
module tb_lsu_mem_master;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h0800_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  lsu_mem_master_if bus ();
  lsu_mem_master #(.PMEM_BASE(BASE), .PMEM_SIZE(SIZE)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] m_err(input logic [63:0] a, input logic [1:0] sz);
    logic [64:0] n;
    n = 65'd1 << sz;
    if (a % n[63:0] != 64'd0) return 2'b01;
    if (a < BASE || ({1'b0, a} + n) > ({1'b0, BASE} + {1'b0, SIZE})) return 2'b10;
    return 2'b00;
  endfunction
  function automatic logic [63:0] m_ext(input logic [63:0] raw, input logic [1:0] sz, input logic sg);
    int bits;
    logic [63:0] lo, v;
    bits = 8 << sz;
    if (sz == 2'd3) return raw;
    lo = (64'd1 << bits) - 64'd1;
    v  = raw & lo;
    if (sg && v[bits-1]) v = v | ~lo;
    return v;
  endfunction
  task automatic drive_junk();
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = BASE + 64'($urandom_range(0, 255));
    bus.req_wdata  = {$urandom, $urandom};
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_we_en"}, bus.mem_we_en, 0);
  endtask
  task automatic xact(input logic w, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                      input logic [63:0] wd, input logic [63:0] rd, input int hold);
    logic [1:0]  e;
    logic [63:0] er;
    e  = m_err(a, sz);
    er = (w || e != 2'b00) ? 64'd0 : m_ext(rd, sz, sg);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd; bus.mem_rd_data = rd;
    chk("req_ready_pre", bus.req_ready, 1);
    @(posedge clk); #1;
    drive_junk();
    chk("rd_en_access", bus.mem_rd_en, !w && e == 2'b00);
    chk("we_en_access", bus.mem_we_en, w && e == 2'b00);
    if (!w && e == 2'b00) chk("rd_addr", bus.mem_rd_addr, a);
    if (w && e == 2'b00) begin
      chk("we_addr", bus.mem_we_addr, a);
      chk("we_data", bus.mem_we_data, m_ext(wd, sz, 1'b0));
      chk("we_mask", bus.mem_we_mask, 64'(8'((16'd1 << (1 << sz)) - 16'd1)));
    end
    chk("resp_valid_access", bus.resp_valid, 0);
    chk("req_ready_access", bus.req_ready, 0);
    @(posedge clk); #1;
    bus.mem_rd_data = {$urandom, $urandom};
    chk("rd_en_resp", bus.mem_rd_en, 0);
    chk("we_en_resp", bus.mem_we_en, 0);
    chk("resp_valid", bus.resp_valid, 1);
    chk("resp_rdata", bus.resp_rdata, er);
    chk("resp_err", bus.resp_err, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_rdata", bus.resp_rdata, er);
      chk("hold_err", bus.resp_err, e);
      chk("hold_req_ready", bus.req_ready, 0);
      chk("hold_en", {bus.mem_rd_en, bus.mem_we_en}, 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check_idle_outputs("after_resp");
  endtask
  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0; bus.mem_rd_data = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    check_idle_outputs("reset_mid");
    chk("reset_mem", {bus.mem_rd_addr, bus.mem_we_addr} | {bus.mem_we_data, 56'd0, bus.mem_we_mask}, 0);
    chk("reset_resp", {62'd0, bus.resp_err} | bus.resp_rdata, 0);
    @(posedge clk); #1;
    check_idle_outputs("reset_edge");
    xact(1, 2'd3, 0, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 0);
    xact(0, 2'd0, 1, 64'h8000_0003, 64'h1234_5678_9ABC_DE80, 64'h1234_5678_9ABC_DE80, 0);
    chk("ldb_signed_model", m_ext(64'h80, 2'd0, 1'b1), 64'hFFFF_FFFF_FFFF_FF80);
    xact(0, 2'd0, 0, 64'h8000_0003, 64'h0, 64'h1234_5678_9ABC_DE80, 1);
    xact(0, 2'd2, 1, 64'h8000_0002, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    xact(1, 2'd2, 0, 64'h87FF_FFFC, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 0);
    xact(1, 2'd3, 0, 64'h8800_0000, 64'h1, 64'd0, 0);
    xact(0, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h55, 0);
    xact(0, 2'd1, 1, 64'h7FFF_FFFE, 64'h0, 64'h8000, 0);
    xact(1, 2'd3, 0, 64'h8000_0100, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 5);
    bus.req_valid = 1; bus.req_write = 1; bus.req_size = 2'd3; bus.req_signed = 0;
    bus.req_addr = 64'h8000_0040; bus.req_wdata = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    bus.req_valid = 0;
    chk("rst_access_we_en", bus.mem_we_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_we_en", bus.mem_we_en, 0);
    chk("rst_async_resp_valid", bus.resp_valid, 0);
    chk("rst_async_req_ready", bus.req_ready, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_idle_outputs("rst_no_resp");
    end
    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom);
      case ($urandom % 4)
        0: a = BASE + 64'($urandom_range(0, 32'h07FF_FFFF));
        1: a = BASE + SIZE - 64'($urandom_range(0, 16));
        2: a = BASE - 64'($urandom_range(1, 16));
        default: a = {$urandom, $urandom};
      endcase
      if ($urandom % 2) a = a & ~((64'd1 << sz) - 64'd1);
      xact(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that drives the simulation physical-memory port (rd_en/rd_addr/rd_data, we_en/we_addr/we_data/we_mask) on behalf of the core's memory stage. It accepts one load or store request at a time over a valid/ready handshake. It checks alignment and address range, and issues exactly one registered, glitch-free memory enable per accepted request. It returns sign- or zero-extended load data with an error code over a valid/ready response channel.

## Interface
- PMEM_BASE, 64'h8000_0000, first legal physical address
- PMEM_SIZE, 64'h0800_0000, size of the legal window in bytes
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_signed  in  1  sign-extend load result; ignored for stores and for size 3
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 access fault
- mem_rd_en  out  1  memory read enable
- mem_rd_addr  out  64  read address
- mem_rd_data  in  64  combinational read data; target bytes are in the low lanes
- mem_we_en  out  1  memory write enable
- mem_we_addr  out  64  write address
- mem_we_data  out  64  write data, right-justified, bits above the access size forced to 0
- mem_we_mask  out  8  8'h01 / 8'h03 / 8'h0F / 8'hFF for size 0..3

## Operation
- FSM states:
  - IDLE: req_ready = 1.
  - ACCESS: exactly one cycle.
  - RESP: resp_valid = 1.
- Transitions:
  - IDLE → ACCESS on req_valid && req_ready. All request fields are latched on that edge.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE on resp_ready.
- Error check, evaluated at acceptance:
  - Misaligned: (addr & (2^size − 1)) != 0. Misaligned takes priority over access fault.
  - Access fault: addr < PMEM_BASE, or addr + 2^size > PMEM_BASE + PMEM_SIZE. Compute the sum in 65 bits so wrap-around never passes the check.
- Memory enables:
  - The enable flops are set on the accept edge and cleared on the next edge, so each enable is high for the whole ACCESS cycle only.
  - mem_rd_en is set only for error-free loads; mem_we_en only for error-free stores. Never both at once.
  - Errored requests assert no enable.
- Memory address and data:
  - Address, data and mask outputs are registers loaded on the accept edge.
  - They hold their values outside ACCESS, but carry meaning only while the matching enable is high.
- Load data:
  - resp_rdata is captured from mem_rd_data at the end of ACCESS.
  - Extraction uses the low 2^size bytes, extended per req_signed.
- Stores: resp_rdata = 0.
- Errored requests: resp_rdata = 0, resp_err is set, and the response still arrives on normal timing.
- resp_rdata and resp_err stay stable while resp_valid && !resp_ready.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, all mem_* outputs 0, resp_rdata 0, resp_err 0.
- Request accepted at edge N:
  - Memory enable is high during cycle N+1.
  - resp_valid rises after edge N+1 (cycle N+2 onward).
- Throughput: at most one request per 3 cycles. req_ready stays 0 from acceptance until the response handshake completes.
- A response handshake and a new request cannot be accepted in the same cycle.
- Reset asserted mid-operation:
  - Enables and resp_valid drop asynchronously.
  - The pending request is discarded and no response is ever produced for it.
- All mem_* outputs come directly from flops. They must be free of combinational glitches, because the downstream memory performs side-effecting writes on any level change.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_B / SZ_H / SZ_W / SZ_D;
  - error codes ERR_OK / ERR_MISALIGN / ERR_FAULT;
  - the FSM state enum;
  - a mask-from-size constant function.
- Sub-module lsu_load_ext: combinational extraction and extension (64-bit raw data, size, signed → 64-bit result), instantiated once.

## Test plan
- Reset: hold reset 3 cycles → req_ready 1, resp_valid 0, all mem_* 0, also when reset releases mid-cycle.
- Store double: 0x8000_0008 with data 0x1122_3344_5566_7788 → mem_we_en high for exactly one cycle with mask 0xFF, addr 0x8000_0008, data unchanged. resp_err 00 and resp_rdata 0 two cycles after accept.
- Load byte at 0x8000_0003 with mem_rd_data 0x...0080:
  - signed → resp_rdata 0xFFFF_FFFF_FFFF_FF80;
  - unsigned → 0x80;
  - mem_rd_en exactly one cycle.
- Misaligned load word at 0x8000_0002 → resp_err 01, resp_rdata 0, no enable at any cycle.
- Range boundary:
  - store word at 0x87FF_FFFC → ok, mask 0x0F, mem_we_data upper 32 bits 0;
  - store double at 0x8800_0000 → err 10;
  - load double at 0xFFFF_FFFF_FFFF_FFF8 → err 10, no wrap.
- Backpressure and reset:
  - hold resp_ready 0 for 5 cycles → response stable, req_ready 0, no second enable;
  - separately, assert reset during ACCESS of a store → mem_we_en falls immediately and no response appears.
